// File: rtl/running_extrema_reg.sv
// Running minimum/maximum tracker with sample indices, a saturating sample count
// and a three-state run controller (IDLE -> TRACK -> DONE).
module running_extrema_reg #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    // Starting values chosen so the first accepted sample always replaces both extrema.
    localparam logic [WIDTH-1:0] MIN_START = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_START = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   accept;

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED)
            return $signed(a) < $signed(b);
        else
            return a < b;
    endfunction

    // init wins over a coincident sample, so that sample is never accepted.
    assign accept = (state == TRACK) && in_valid && !init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (init) begin
            state_nxt = TRACK;
        end else begin
            case (state)
                TRACK:   if (in_valid && in_last) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == TRACK);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_out <= '0;
            max_out <= '0;
            min_idx <= '0;
            max_idx <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (init) begin
            min_out <= MIN_START;
            max_out <= MAX_START;
            min_idx <= '0;
            max_idx <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            // Strict compares keep the earlier index on ties.
            if (less_than(in_data, min_out)) begin
                min_out <= in_data;
                min_idx <= count;
            end
            if (less_than(max_out, in_data)) begin
                max_out <= in_data;
                max_idx <= count;
            end
            if (count != CNT_MAX)
                count <= count + 1'b1;
            else
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_running_extrema_reg.sv
// Directed bench for running_extrema_reg: signed, unsigned and narrow-counter
// instances share one stimulus stream, each run starting with init.
module tb_running_extrema_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;

    logic [7:0] s_min, s_max, s_min_idx, s_max_idx, s_count;
    logic       s_busy, s_done, s_ovf;
    logic [7:0] u_min, u_max, u_min_idx, u_max_idx, u_count;
    logic       u_busy, u_done, u_ovf;
    logic [7:0] n_min, n_max;
    logic [1:0] n_min_idx, n_max_idx, n_count;
    logic       n_busy, n_done, n_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    running_extrema_reg #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .min_out(s_min), .max_out(s_max), .min_idx(s_min_idx),
        .max_idx(s_max_idx), .count(s_count), .busy(s_busy), .done(s_done), .ovf(s_ovf));

    running_extrema_reg #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .min_out(u_min), .max_out(u_max), .min_idx(u_min_idx),
        .max_idx(u_max_idx), .count(u_count), .busy(u_busy), .done(u_done), .ovf(u_ovf));

    running_extrema_reg #(.WIDTH(8), .CNT_W(2), .SIGNED(1'b1)) dut_n (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .min_out(n_min), .max_out(n_max), .min_idx(n_min_idx),
        .max_idx(n_max_idx), .count(n_count), .busy(n_busy), .done(n_done), .ovf(n_ovf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic i_init, input logic i_vld, input logic [7:0] i_data,
                        input logic i_last);
        init     = i_init;
        in_valid = i_vld;
        in_data  = i_data;
        in_last  = i_last;
        @(posedge clk);
        #1;
        init     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
    endtask

    initial begin
        // Reset state, observed before any clock edge.
        #2;
        check("rst_min", s_min, 0);
        check("rst_max", s_max, 0);
        check("rst_count", s_count, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_ovf", s_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE ignores samples.
        step(0, 1, 8'h10, 0);
        check("idle_count", s_count, 0);
        check("idle_busy", s_busy, 0);

        // Identity values after init.
        step(1, 0, 8'h00, 0);
        check("init_min", s_min, 8'h7F);
        check("init_max", s_max, 8'h80);
        check("init_count", s_count, 0);
        check("init_busy", s_busy, 1);
        check("init_done", s_done, 0);
        check("u_init_min", u_min, 8'hFF);
        check("u_init_max", u_max, 8'h00);

        // Zero-sample run: idle cycles keep identities, in_last alone ignored.
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("empty_busy", s_busy, 1);
        check("empty_done", s_done, 0);
        check("empty_min", s_min, 8'h7F);

        // Signed run: 5, -3, 12, -3(last).
        step(0, 1, 8'd5, 0);
        check("s1_min", s_min, 8'd5);
        check("s1_max", s_max, 8'd5);
        check("s1_count", s_count, 1);
        step(0, 1, 8'hFD, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'd12, 0);
        step(0, 1, 8'hFD, 1);
        check("run_min", s_min, 8'hFD);
        check("run_min_idx", s_min_idx, 1);
        check("run_max", s_max, 8'h0C);
        check("run_max_idx", s_max_idx, 2);
        check("run_count", s_count, 4);
        check("run_done", s_done, 1);
        check("run_busy", s_busy, 0);

        // DONE holds regardless of further samples.
        step(0, 1, 8'h7F, 1);
        check("hold_max", s_max, 8'h0C);
        check("hold_count", s_count, 4);
        check("hold_done", s_done, 1);

        // Unsigned: 0x80, 0x01(last).
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h80, 0);
        step(0, 1, 8'h01, 1);
        check("u_min", u_min, 8'h01);
        check("u_min_idx", u_min_idx, 1);
        check("u_max", u_max, 8'h80);
        check("u_max_idx", u_max_idx, 0);
        check("u_done", u_done, 1);
        check("s_cmp_max", s_max, 8'h01);

        // init beats coincident sample.
        step(1, 1, 8'h00, 0);
        check("drop_count", s_count, 0);
        check("drop_min", s_min, 8'h7F);
        check("drop_busy", s_busy, 1);

        // Narrow counter saturation: samples 1..5, last on 5th.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'd1, 0);
        step(0, 1, 8'd2, 0);
        step(0, 1, 8'd3, 0);
        check("n3_count", n_count, 3);
        check("n3_ovf", n_ovf, 0);
        step(0, 1, 8'd4, 0);
        check("n4_max_idx", n_max_idx, 3);
        check("n4_ovf", n_ovf, 1);
        step(0, 1, 8'd5, 1);
        check("n5_max", n_max, 8'd5);
        check("n5_max_idx", n_max_idx, 3);
        check("n5_min_idx", n_min_idx, 0);
        check("n5_count", n_count, 3);
        check("n5_done", n_done, 1);
        check("s_nosat_count", s_count, 5);
        check("s_nosat_ovf", s_ovf, 0);

        // Asynchronous reset mid-run.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'd9, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_min", s_min, 0);
        check("arst_max", s_max, 0);
        check("arst_count", s_count, 0);
        check("arst_busy", s_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 1, 8'd7, 0);
        step(0, 1, 8'd8, 1);
        check("post_rst_count", s_count, 0);
        check("post_rst_busy", s_busy, 0);
        check("post_rst_done", s_done, 0);
        step(1, 0, 8'h00, 0);
        check("reinit_busy", s_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
